// File: rtl/seq_counter_pkg.sv
// Shared types and helpers for the table-driven sequence counter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package seq_counter_pkg;

    // 4-bit default order 4,5,14,3,6,12,11,13 with entry 0 in the LSBs.
    localparam logic [31:0] DEFAULT_SEQ = {4'd13, 4'd11, 4'd12, 4'd6,
                                           4'd3,  4'd14, 4'd5,  4'd4};

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_STEP = 2'd2
    } op_t;

    // Index is carried at full int width; callers truncate to their IW.
    typedef struct packed {
        logic [31:0] idx;
        logic        wrap;
    } step_t;

    function automatic int eff_len(input int len, input int depth);
        if (len == 0 || len > depth) begin
            return depth;
        end
        return len;
    endfunction

    function automatic step_t next_idx(input int idx, input int l, input logic up);
        step_t s;
        s.idx  = '0;
        s.wrap = 1'b0;
        if (up) begin
            if (idx == l - 1) begin
                s.wrap = 1'b1;
            end else if (idx < l) begin
                s.idx = 32'(idx + 1);
            end
        end else begin
            if (idx == 0) begin
                s.idx  = 32'(l - 1);
                s.wrap = 1'b1;
            end else if (idx < l) begin
                s.idx = 32'(idx - 1);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/seq_table.sv
// DEPTH x W register file holding the counting order, reset to INIT.
// Latency: write lands on the edge, read is combinational.
// Backpressure: none, a write is accepted every cycle wr_en is high.
module seq_table
    import seq_counter_pkg::*;
#(
    parameter int                   W     = 4,
    parameter int                   DEPTH = 8,
    parameter logic [DEPTH*W-1:0]   INIT  = DEFAULT_SEQ,
    parameter int                   IW    = $clog2(DEPTH)
) (
    input  logic            C,
    input  logic            nR,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_addr,
    input  logic [W-1:0]    wr_data,
    input  logic [IW-1:0]   rd_addr,
    output logic [W-1:0]    rd_dat
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge C) begin
        if (!nR) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT[i*W +: W];
            end
        end else if (wr_en && int'(wr_addr) < DEPTH) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Addresses past DEPTH only exist when DEPTH is not a power of two.
    always_comb begin
        rd_dat = '0;
        if (int'(rd_addr) < DEPTH) begin
            rd_dat = mem[rd_addr];
        end
    end

endmodule

// File: rtl/seq_counter.sv
// Programmable-order counter: an index walks a writable value table.
// Latency: idx/tc registered, Q is a combinational read of table[idx].
// Backpressure: none, en advances one step on every enabled edge.
module seq_counter
    import seq_counter_pkg::*;
#(
    parameter int                   W     = 4,
    parameter int                   DEPTH = 8,
    parameter logic [DEPTH*W-1:0]   INIT  = DEFAULT_SEQ,
    parameter int                   IW    = $clog2(DEPTH),
    parameter int                   LW    = $clog2(DEPTH + 1)
) (
    input  logic            C,
    input  logic            nR,
    input  logic            en,
    input  logic            up,
    input  logic            ld,
    input  logic [IW-1:0]   ld_idx,
    input  logic [LW-1:0]   len,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_addr,
    input  logic [W-1:0]    wr_data,
    output logic [W-1:0]    Q,
    output logic [IW-1:0]   idx,
    output logic            tc
);

    op_t            op;
    int             l_eff;
    step_t          step;
    logic [IW-1:0]  idx_nxt;
    logic           tc_nxt;

    always_comb begin
        op      = OP_HOLD;
        l_eff   = eff_len(int'(len), DEPTH);
        step    = next_idx(int'(idx), l_eff, up);
        idx_nxt = idx;
        tc_nxt  = 1'b0;

        if (ld) begin
            op = OP_LOAD;
        end else if (en) begin
            op = OP_STEP;
        end

        case (op)
            OP_LOAD: begin
                // Out-of-range loads snap to the start rather than a stale slot.
                idx_nxt = (int'(ld_idx) < l_eff) ? ld_idx : '0;
            end
            OP_STEP: begin
                idx_nxt = IW'(step.idx);
                tc_nxt  = step.wrap;
            end
            default: begin
                idx_nxt = idx;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (!nR) begin
            idx <= '0;
            tc  <= 1'b0;
        end else begin
            idx <= idx_nxt;
            tc  <= tc_nxt;
        end
    end

    seq_table #(
        .W     (W),
        .DEPTH (DEPTH),
        .INIT  (INIT),
        .IW    (IW)
    ) u_table (
        .C       (C),
        .nR      (nR),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx),
        .rd_dat  (Q)
    );

endmodule

// File: tb/tb_seq_counter.sv
// Directed vector bench for seq_counter with the default 8-entry table.
module tb_seq_counter;

    logic       C = 1'b0;
    logic       nR, en, up, ld, wr_en;
    logic [2:0] ld_idx, wr_addr, idx;
    logic [3:0] len, wr_data, Q;
    logic       tc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 C = ~C;

    seq_counter dut (
        .C       (C),
        .nR      (nR),
        .en      (en),
        .up      (up),
        .ld      (ld),
        .ld_idx  (ld_idx),
        .len     (len),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .Q       (Q),
        .idx     (idx),
        .tc      (tc)
    );

    typedef struct {
        logic       nr, en, up, ld;
        logic [2:0] ld_idx;
        logic [3:0] len;
        logic       wr_en;
        logic [2:0] wr_addr;
        logic [3:0] wr_data;
        logic [3:0] eq;
        logic [2:0] eidx;
        logic       etc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic n, input logic e, input logic u, input logic l,
                                input int li, input int ln, input logic we, input int wa,
                                input int wd, input int q, input int i, input logic t);
        vec_t v;
        v.nr = n; v.en = e; v.up = u; v.ld = l;
        v.ld_idx = 3'(li); v.len = 4'(ln);
        v.wr_en = we; v.wr_addr = 3'(wa); v.wr_data = 4'(wd);
        v.eq = 4'(q); v.eidx = 3'(i); v.etc = t;
        return v;
    endfunction

    task automatic drive(input logic n, input logic e, input logic u, input logic l,
                         input logic [2:0] li, input logic [3:0] ln, input logic we,
                         input logic [2:0] wa, input logic [3:0] wd);
        nR = n; en = e; up = u; ld = l; ld_idx = li; len = ln;
        wr_en = we; wr_addr = wa; wr_data = wd;
    endtask

    task automatic check(input string name, input int k, input logic [3:0] eq,
                         input logic [2:0] ei, input logic et);
        n_cmp++;
        if (Q !== eq) begin
            n_bad++;
            $display("FAIL %s[%0d] Q got %0d want %0d", name, k, Q, eq);
        end
        n_cmp++;
        if (idx !== ei) begin
            n_bad++;
            $display("FAIL %s[%0d] idx got %0d want %0d", name, k, idx, ei);
        end
        n_cmp++;
        if (tc !== et) begin
            n_bad++;
            $display("FAIL %s[%0d] tc got %0d want %0d", name, k, tc, et);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 1, 0, 0, 8, 0, 0, 0);

        // reset
        vecs.push_back(mk(0,0,1,0,0,8,0,0,0,  4,0,0));
        // up count, full length
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0,  5,1,0));
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0, 14,2,0));
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0,  3,3,0));
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0,  6,4,0));
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0, 12,5,0));
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0, 11,6,0));
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0, 13,7,0));
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0,  4,0,1));
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0,  5,1,0));
        // reset overrides en; then down count
        vecs.push_back(mk(0,1,1,0,0,8,0,0,0,  4,0,0));
        vecs.push_back(mk(1,1,0,0,0,8,0,0,0, 13,7,1));
        vecs.push_back(mk(1,1,0,0,0,8,0,0,0, 11,6,0));
        vecs.push_back(mk(1,1,0,0,0,8,0,0,0, 12,5,0));
        vecs.push_back(mk(1,1,0,0,0,8,0,0,0,  6,4,0));
        vecs.push_back(mk(1,1,0,0,0,8,0,0,0,  3,3,0));
        vecs.push_back(mk(1,1,0,0,0,8,0,0,0, 14,2,0));
        vecs.push_back(mk(1,1,0,0,0,8,0,0,0,  5,1,0));
        vecs.push_back(mk(1,1,0,0,0,8,0,0,0,  4,0,0));
        vecs.push_back(mk(1,1,0,0,0,8,0,0,0, 13,7,1));
        // short length 3
        vecs.push_back(mk(0,0,1,0,0,3,0,0,0,  4,0,0));
        vecs.push_back(mk(1,1,1,0,0,3,0,0,0,  5,1,0));
        vecs.push_back(mk(1,1,1,0,0,3,0,0,0, 14,2,0));
        vecs.push_back(mk(1,1,1,0,0,3,0,0,0,  4,0,1));
        vecs.push_back(mk(1,1,1,0,0,3,0,0,0,  5,1,0));
        vecs.push_back(mk(1,1,1,0,0,3,0,0,0, 14,2,0));
        vecs.push_back(mk(1,1,1,0,0,3,0,0,0,  4,0,1));
        // walk to idx 6, then shrink length under it
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0,  5,1,0));
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0, 14,2,0));
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0,  3,3,0));
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0,  6,4,0));
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0, 12,5,0));
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0, 11,6,0));
        vecs.push_back(mk(1,1,1,0,0,3,0,0,0,  4,0,0));
        // len 0 means full table
        vecs.push_back(mk(1,1,1,0,0,0,0,0,0,  5,1,0));
        vecs.push_back(mk(1,1,1,0,0,0,0,0,0, 14,2,0));
        vecs.push_back(mk(1,1,1,0,0,0,0,0,0,  3,3,0));
        vecs.push_back(mk(1,1,1,0,0,0,0,0,0,  6,4,0));
        vecs.push_back(mk(1,1,1,0,0,0,0,0,0, 12,5,0));
        vecs.push_back(mk(1,1,1,0,0,0,0,0,0, 11,6,0));
        vecs.push_back(mk(1,1,1,0,0,0,0,0,0, 13,7,0));
        vecs.push_back(mk(1,1,1,0,0,0,0,0,0,  4,0,1));
        // load wins over en and clears tc
        vecs.push_back(mk(1,1,0,0,0,8,0,0,0, 13,7,1));
        vecs.push_back(mk(1,1,1,1,5,8,0,0,0, 12,5,0));
        vecs.push_back(mk(1,0,1,1,6,4,0,0,0,  4,0,0));
        vecs.push_back(mk(1,0,1,1,3,4,0,0,0,  3,3,0));
        vecs.push_back(mk(1,0,1,0,0,4,0,0,0,  3,3,0));
        // length 1 and length above DEPTH
        vecs.push_back(mk(1,1,1,0,0,1,0,0,0,  4,0,0));
        vecs.push_back(mk(1,1,1,0,0,1,0,0,0,  4,0,1));
        vecs.push_back(mk(1,1,0,0,0,1,0,0,0,  4,0,1));
        vecs.push_back(mk(1,1,1,0,0,9,0,0,0,  5,1,0));
        vecs.push_back(mk(1,1,0,0,0,15,0,0,0, 4,0,0));
        // write into the entry the index moves to
        vecs.push_back(mk(1,0,1,1,2,8,0,0,0, 14,2,0));
        vecs.push_back(mk(1,1,1,0,0,8,1,3,9,  9,3,0));
        vecs.push_back(mk(1,1,1,0,0,8,0,0,0,  6,4,0));
        vecs.push_back(mk(1,0,1,1,3,8,0,0,0,  9,3,0));
        vecs.push_back(mk(1,0,1,0,0,8,1,3,7,  7,3,0));
        vecs.push_back(mk(1,1,0,1,0,8,0,0,0,  4,0,0));
        vecs.push_back(mk(1,1,0,0,0,8,0,0,0, 13,7,1));
        // reset mid-count restores the table and drops tc
        vecs.push_back(mk(0,1,1,1,5,8,1,3,1,  4,0,0));
        vecs.push_back(mk(1,0,1,1,3,8,0,0,0,  3,3,0));

        foreach (vecs[k]) begin
            drive(vecs[k].nr, vecs[k].en, vecs[k].up, vecs[k].ld, vecs[k].ld_idx,
                  vecs[k].len, vecs[k].wr_en, vecs[k].wr_addr, vecs[k].wr_data);
            tick();
            check("vec", k, vecs[k].eq, vecs[k].eidx, vecs[k].etc);
        end

        // tc lasts one cycle at length 2, then drops on a hold
        drive(1, 1, 1, 0, 0, 2, 0, 0, 0); tick(); check("len2", 0, 4, 0, 0);
        tick();                               check("len2", 1, 5, 1, 0);
        tick();                               check("len2", 2, 4, 0, 1);
        en = 1'b0;   tick();                  check("len2", 3, 4, 0, 0);

        // reset held several cycles with everything active
        drive(1, 1, 1, 0, 0, 8, 0, 0, 0); tick(); tick(); check("rsthold", 0, 14, 2, 0);
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, 1, 1, 6, 8, 1, 0, 15);
            tick();
            check("rsthold", k, 4, 0, 0);
        end
        drive(1, 1, 1, 0, 0, 8, 0, 0, 0); tick(); check("rsthold", 4, 5, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
